jam_n: RTL and testbench
========================

# jam_n

Parametrised job-assignment solver, the next generation of the fixed 8×8 JAM engine. It finds the minimum total cost of assigning N workers to N jobs one-to-one, and counts how many assignments reach that minimum. It enumerates all N! permutations in lexicographic order and reads costs from an external cost ROM through a W/J address port with one-cycle read latency. Unlike its predecessor, it has a START/BUSY handshake, can be rerun without reset, and saturates its match counter.

## Interface
- N, 8 — workers = jobs, legal range 2..8
- CW, 7 — Cost width
- IW, $clog2(N) (minimum 1) — W/J index width, derived
- SW, CW+$clog2(N) — sum and MinCost width
- MCW, 16 — MatchCount width; N=8 needs 16 bits to hold 40320
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  starts a run when sampled high in IDLE
- BUSY  out  1  high from the cycle after START is accepted until Valid
- W  out  IW  worker index of the cost request
- J  out  IW  job index of the cost request
- Cost  in  CW  cost[W][J] for the address sampled at the previous edge
- MinCost  out  SW  minimum total cost
- MatchCount  out  MCW  number of permutations with the minimum cost
- Valid  out  1  one-cycle pulse when the run is done
- BestPerm  out  N*IW  job assigned to each worker w, at bits [w*IW +: IW]; present only with JAM_BEST_PERM_EN

## Operation
- Reset values:
  - W=0, J=0, BUSY=0, Valid=0
  - MinCost=0, MatchCount=0, BestPerm=0
  - state IDLE, internal min=all-ones, perm=identity
- States:
  - IDLE: START → FETCH. Clears sum, sets min=all-ones, count=0, perm=identity (perm[w]=w), k=0.
  - FETCH: drives W=k, J=perm[k]. From cycle 2 of FETCH on, adds the previous cycle's Cost to sum. Goes to ACC when k=N-1.
  - ACC: adds the last Cost, then → UPDATE.
  - UPDATE:
    - sum<min: min=sum, count=1.
    - sum==min: count+1, saturating at 2^MCW-1.
    - Clears sum.
    - If perm is the last (descending) permutation → DONE; otherwise perm=next_perm(perm), k=0 → FETCH.
  - DONE: MinCost=min, MatchCount=count, Valid=1, BUSY=0 → IDLE.
- next_perm steps:
  - Find the largest i with p[i]<p[i+1].
  - Find the largest j>i with p[j]>p[i].
  - Swap p[i] and p[j], then reverse p[i+1..N-1].
  - "Last" means no such i exists.
- W/J hold their last values outside FETCH.
- Results stay held after Valid until the next DONE.
- START while BUSY is ignored. START in the DONE cycle is ignored.
- Arithmetic:
  - The sum is an unsigned SW-bit value and cannot overflow (N·(2^CW-1) < 2^SW).
  - Cost is zero-extended.
- RST_N low mid-run aborts immediately. All outputs return to reset values and no Valid is produced.

## Timing
- START is sampled at edge T. The first address (W=0, J=perm[0]) is driven from edge T+1.
- Cost is sampled one edge after its address.
- Each permutation takes N+2 cycles: N FETCH, 1 ACC, 1 UPDATE.
- Valid is high in the cycle following edge T+N!·(N+2). For N=8 that is edge T+403200.
- BUSY is high from edge T through the cycle before Valid.
- Back-to-back runs: START may be accepted in the first IDLE cycle after Valid.

## Configuration
- JAM_BEST_PERM_EN:
  - Defined: the BestPerm port exists. It records the perm for which sum<min was first true, so it holds the lexicographically first minimum. It is loaded in DONE and reset to 0.
  - Undefined: the port and its registers are absent. All other behaviour and timing are identical.

## Structure
- Package jam_pkg:
  - state enum (IDLE, FETCH, ACC, UPDATE, DONE)
  - N_MAX=8 constant
  - factorial function used for assertions
- Sub-module jam_next_perm: purely combinational. Takes perm (N*IW) and produces next perm plus an is_last flag. The FSM, accumulator, comparator and counter live in jam_n.

## Test plan
- N=2, cost {{1,2},{3,4}} → MinCost=5, MatchCount=2, Valid 8 cycles after the START edge.
- N=3, cost 1 on the diagonal and 10 elsewhere, with JAM_BEST_PERM_EN → MinCost=3, MatchCount=1, BestPerm = identity (0,1,2).
- N=4, all costs 5 → MinCost=20, MatchCount=24. Rerun with different costs without reset → fresh result (min and count not carried over).
- N=8, CW=7, all costs 127 → MinCost=1016, MatchCount=40320. Valid in the cycle after edge T+403200.
- N=4, MCW=4, all costs equal → MatchCount saturates at 15.
- START pulsed while BUSY → ignored, result unchanged. RST_N low mid-run → Valid never pulses and outputs return to 0. A restart then gives the correct result.

Source files
------------

// File: rtl/jam_pkg.sv
// -----------------------------------------------------------------------------
// jam_pkg
//   Shared definitions for the jam_n job-assignment solver:
//     - FSM state encoding (IDLE, FETCH, ACC, UPDATE, DONE)
//     - N_MAX, the largest supported worker/job count
//     - factorial(), used by the solver's run-result assertion
//   No ports; imported with `import jam_pkg::*;`.
// -----------------------------------------------------------------------------
package jam_pkg;

    localparam int N_MAX = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t FETCH  = 3'd1;
    localparam state_t ACC    = 3'd2;
    localparam state_t UPDATE = 3'd3;
    localparam state_t DONE   = 3'd4;

    function automatic int unsigned factorial(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// -----------------------------------------------------------------------------
// jam_next_perm
//   Purely combinational lexicographic successor of a permutation.
//   Ports:
//     perm      in   N*IW  current permutation, element w at [w*IW +: IW]
//     next_perm out  N*IW  lexicographic successor (don't-care when is_last)
//     is_last   out  1     perm is fully descending, no successor exists
// -----------------------------------------------------------------------------
module jam_next_perm #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N*IW-1:0] perm,
    output logic [N*IW-1:0] next_perm,
    output logic            is_last
);

    logic [IW-1:0] p [N];
    logic [IW-1:0] s [N];
    logic [IW-1:0] pi_val;
    logic [IW-1:0] pj_val;
    logic          found;
    int            i_idx;
    int            j_idx;

    // All element selects are written as equality-matched loops so every
    // index into the unpacked arrays is a loop constant.
    always_comb begin
        found  = 1'b0;
        i_idx  = 0;
        j_idx  = 0;
        pi_val = '0;
        pj_val = '0;
        for (int w = 0; w < N; w++) p[w] = perm[w*IW +: IW];

        // Pivot: largest i with p[i] < p[i+1].
        for (int i = 0; i < N - 1; i++) begin
            if (p[i] < p[i+1]) begin
                found  = 1'b1;
                i_idx  = i;
                pi_val = p[i];
            end
        end

        // Largest j beyond the pivot holding a larger value.
        for (int j = 1; j < N; j++) begin
            if (j > i_idx && p[j] > pi_val) begin
                j_idx  = j;
                pj_val = p[j];
            end
        end

        for (int m = 0; m < N; m++) begin
            if (m == i_idx)      s[m] = pj_val;
            else if (m == j_idx) s[m] = pi_val;
            else                 s[m] = p[m];
        end

        // Reverse the suffix after the pivot: position m takes s[N+i-m].
        next_perm = '0;
        for (int m = 0; m < N; m++) begin
            next_perm[m*IW +: IW] = s[m];
            for (int r = 0; r < N; r++) begin
                if (m > i_idx && r == N + i_idx - m) next_perm[m*IW +: IW] = s[r];
            end
        end

        is_last = ~found;
    end

endmodule

// File: rtl/jam_n.sv
// -----------------------------------------------------------------------------
// jam_n
//   Exhaustive job-assignment solver. Walks all N! permutations in
//   lexicographic order, fetching cost[W][J] from an external ROM whose data
//   is sampled one edge after the address is driven, and reports the minimum
//   total cost and how many permutations reach it (saturating counter).
//   Optional feature macro: JAM_BEST_PERM_EN adds the BestPerm output.
//   Ports:
//     CLK        in   1      clock, rising edge
//     RST_N      in   1      asynchronous active-low reset
//     START      in   1      start a run when sampled high in IDLE
//     BUSY       out  1      run in progress
//     W, J       out  IW     cost ROM address (worker, job)
//     Cost       in   CW     cost for the address driven in the previous cycle
//     MinCost    out  SW     minimum total cost of the last run
//     MatchCount out  MCW    permutations reaching MinCost (saturating)
//     Valid      out  1      one-cycle pulse when results update
//     BestPerm   out  N*IW   lexicographically first optimal assignment
//                            (only with JAM_BEST_PERM_EN)
// -----------------------------------------------------------------------------
module jam_n
    import jam_pkg::*;
#(
    parameter int N   = 8,
    parameter int CW  = 7,
    parameter int IW  = ($clog2(N) < 1) ? 1 : $clog2(N),
    parameter int SW  = CW + $clog2(N),
    parameter int MCW = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    output logic            BUSY,
    output logic [IW-1:0]   W,
    output logic [IW-1:0]   J,
    input  logic [CW-1:0]   Cost,
    output logic [SW-1:0]   MinCost,
    output logic [MCW-1:0]  MatchCount,
    output logic            Valid
`ifdef JAM_BEST_PERM_EN
    ,
    output logic [N*IW-1:0] BestPerm
`endif
);

    function automatic logic [N*IW-1:0] identity_perm();
        logic [N*IW-1:0] r;
        r = '0;
        for (int w = 0; w < N; w++) r[w*IW +: IW] = IW'(w);
        return r;
    endfunction

    function automatic logic [MCW-1:0] sat_inc(input logic [MCW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_t          state;
    logic [IW-1:0]   k;
    logic [N*IW-1:0] perm;
    logic [N*IW-1:0] perm_next;
    logic            perm_is_last;
    logic [SW-1:0]   sum;
    logic [SW-1:0]   min_cost;
    logic [MCW-1:0]  count;
    logic [SW-1:0]   cost_ext;
    logic [SW-1:0]   sum_acc;
    logic [IW-1:0]   perm_k;
    logic            less;
    logic [SW-1:0]   new_min;
    logic [MCW-1:0]  new_count;
`ifdef JAM_BEST_PERM_EN
    logic [N*IW-1:0] best;
`endif

    jam_next_perm #(.N(N), .IW(IW)) u_next_perm (
        .perm      (perm),
        .next_perm (perm_next),
        .is_last   (perm_is_last)
    );

    assign cost_ext = {{(SW-CW){1'b0}}, Cost};
    assign sum_acc  = sum + cost_ext;
    assign perm_k   = perm[k*IW +: IW];

    // min_cost starts at all-ones, which no sum can reach, so the first
    // permutation of a run always takes the "less" branch.
    assign less      = (sum < min_cost);
    assign new_min   = less ? sum : min_cost;
    assign new_count = less ? MCW'(1) : ((sum == min_cost) ? sat_inc(count) : count);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            k          <= '0;
            perm       <= identity_perm();
            sum        <= '0;
            min_cost   <= '1;
            count      <= '0;
            W          <= '0;
            J          <= '0;
            BUSY       <= 1'b0;
            Valid      <= 1'b0;
            MinCost    <= '0;
            MatchCount <= '0;
`ifdef JAM_BEST_PERM_EN
            best       <= '0;
            BestPerm   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state    <= FETCH;
                        BUSY     <= 1'b1;
                        sum      <= '0;
                        min_cost <= '1;
                        count    <= '0;
                        perm     <= identity_perm();
                        k        <= '0;
                    end
                end
                FETCH: begin
                    W <= k;
                    J <= perm_k;
                    // The cost for address k-1 arrives while address k is issued.
                    if (k != '0) sum <= sum_acc;
                    if (k == IW'(N-1)) state <= ACC;
                    else               k     <= k + 1'b1;
                end
                ACC: begin
                    sum   <= sum_acc;
                    state <= UPDATE;
                end
                UPDATE: begin
                    min_cost <= new_min;
                    count    <= new_count;
                    sum      <= '0;
`ifdef JAM_BEST_PERM_EN
                    if (less) best <= perm;
`endif
                    if (perm_is_last) begin
                        // Results are published on entry to DONE so Valid and
                        // the data appear in the same cycle.
                        state      <= DONE;
                        Valid      <= 1'b1;
                        BUSY       <= 1'b0;
                        MinCost    <= new_min;
                        MatchCount <= new_count;
`ifdef JAM_BEST_PERM_EN
                        BestPerm   <= less ? perm : best;
`endif
                    end else begin
                        perm  <= perm_next;
                        k     <= '0;
                        state <= FETCH;
                    end
                end
                DONE: begin
                    Valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A finished run can never report more matches than there are permutations.
    a_count_bound: assert property (@(posedge CLK) disable iff (!RST_N)
        Valid |-> (32'(MatchCount) <= factorial(N)));

endmodule

// File: tb/tb_jam_n.sv
module tb_jam_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start;
    logic [3:0] busy;
    logic [3:0] valid;

    always #5 clk = ~clk;

    // d2: N=2
    logic [0:0]  w2, j2;
    logic [6:0]  c2;
    logic [7:0]  mc2;
    logic [15:0] cnt2;
    // d4: N=4
    logic [1:0]  w4, j4;
    logic [6:0]  c4;
    logic [8:0]  mc4;
    logic [15:0] cnt4;
    // d4s: N=4, 4-bit match counter
    logic [1:0]  w4s, j4s;
    logic [6:0]  c4s;
    logic [8:0]  mc4s;
    logic [3:0]  cnt4s;
    // d6: N=6
    logic [2:0]  w6, j6;
    logic [6:0]  c6;
    logic [9:0]  mc6;
    logic [15:0] cnt6;
`ifdef JAM_BEST_PERM_EN
    logic [1:0]  bp2;
    logic [7:0]  bp4;
    logic [7:0]  bp4s;
    logic [17:0] bp6;
`endif

    logic [6:0] r2  [2][2];
    logic [6:0] r4  [4][4];
    logic [6:0] r4s [4][4];

    // Cost ROMs: data for the address driven at one edge is sampled at the next.
    assign c2  = r2[w2][j2];
    assign c4  = r4[w4][j4];
    assign c4s = r4s[w4s][j4s];
    assign c6  = (w6 <= 3'd5 && j6 <= 3'd5) ? 7'd127 : 7'd0;

    jam_n #(.N(2), .CW(7), .MCW(16)) d2 (
        .CLK(clk), .RST_N(rst_n), .START(start[0]), .BUSY(busy[0]),
        .W(w2), .J(j2), .Cost(c2), .MinCost(mc2), .MatchCount(cnt2),
        .Valid(valid[0])
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(bp2)
`endif
    );

    jam_n #(.N(4), .CW(7), .MCW(16)) d4 (
        .CLK(clk), .RST_N(rst_n), .START(start[1]), .BUSY(busy[1]),
        .W(w4), .J(j4), .Cost(c4), .MinCost(mc4), .MatchCount(cnt4),
        .Valid(valid[1])
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(bp4)
`endif
    );

    jam_n #(.N(4), .CW(7), .MCW(4)) d4s (
        .CLK(clk), .RST_N(rst_n), .START(start[2]), .BUSY(busy[2]),
        .W(w4s), .J(j4s), .Cost(c4s), .MinCost(mc4s), .MatchCount(cnt4s),
        .Valid(valid[2])
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(bp4s)
`endif
    );

    jam_n #(.N(6), .CW(7), .MCW(16)) d6 (
        .CLK(clk), .RST_N(rst_n), .START(start[3]), .BUSY(busy[3]),
        .W(w6), .J(j6), .Cost(c6), .MinCost(mc6), .MatchCount(cnt6),
        .Valid(valid[3])
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(bp6)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill4(input logic [6:0] diag, input logic [6:0] off);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                r4[a][b] = (a == b) ? diag : off;
    endtask

    // Steps one edge (so a DONE cycle becomes IDLE), pulses START for DUT s,
    // and waits up to budget edges for Valid. lat = edges after the START edge.
    // A second START pulse is injected at edge poke (0 = none).
    task automatic run(input int s, input int budget, input int poke, output int lat);
        logic busy_seen;
        @(posedge clk); #1;
        lat = -1;
        start[s] = 1'b1;
        @(posedge clk); #1;
        start[s] = 1'b0;
        busy_seen = busy[s];
        for (int c = 1; c <= budget; c++) begin
            start[s] = (c == poke);
            @(posedge clk); #1;
            if (valid[s]) begin
                lat = c;
                break;
            end
        end
        start[s] = 1'b0;
        check($sformatf("busy_after_start_%0d", s), 64'(busy_seen), 64'(1));
        check($sformatf("busy_low_at_valid_%0d", s), 64'(busy[s]), 64'(0));
    endtask

    initial begin
        int lat;
        int vcount;
        rst_n = 1'b0;
        start = '0;
        r2 = '{'{7'd1, 7'd2}, '{7'd3, 7'd4}};
        fill4(7'd1, 7'd10);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                r4s[a][b] = 7'd3;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(busy[0]),  64'(0));
        check("rst_valid", 64'(valid[0]), 64'(0));
        check("rst_min",   64'(mc2),      64'(0));
        check("rst_count", 64'(cnt2),     64'(0));
        check("rst_w",     64'(w4),       64'(0));
        check("rst_j",     64'(j4),       64'(0));
        rst_n = 1'b1;

        // N=2: perms (0,1)=1+4, (1,0)=2+3, both 5
        run(0, 40, 0, lat);
        check("n2_latency", 64'(lat),  64'(8));
        check("n2_min",     64'(mc2),  64'(5));
        check("n2_count",   64'(cnt2), 64'(2));
        check("n2_last_w",  64'(w2),   64'(1));
        check("n2_last_j",  64'(j2),   64'(0));
`ifdef JAM_BEST_PERM_EN
        check("n2_best",    64'(bp2),  64'(2'b10));
`endif
        @(posedge clk); #1;
        check("n2_valid_pulse", 64'(valid[0]), 64'(0));
        check("n2_min_held",    64'(mc2),      64'(5));

        // N=4: diagonal 1, elsewhere 10
        run(1, 400, 0, lat);
        check("n4_diag_latency", 64'(lat),  64'(144));
        check("n4_diag_min",     64'(mc4),  64'(4));
        check("n4_diag_count",   64'(cnt4), 64'(1));
`ifdef JAM_BEST_PERM_EN
        check("n4_diag_best",    64'(bp4),  64'(8'hE4));
`endif

        // Rerun back-to-back without reset: all costs 5
        fill4(7'd5, 7'd5);
        run(1, 400, 0, lat);
        check("n4_rerun_latency", 64'(lat),  64'(144));
        check("n4_rerun_min",     64'(mc4),  64'(20));
        check("n4_rerun_count",   64'(cnt4), 64'(24));
`ifdef JAM_BEST_PERM_EN
        check("n4_rerun_best",    64'(bp4),  64'(8'hE4));
`endif

        // START pulsed while BUSY: all costs 2
        fill4(7'd2, 7'd2);
        run(1, 400, 30, lat);
        check("n4_poke_latency", 64'(lat),  64'(144));
        check("n4_poke_min",     64'(mc4),  64'(8));
        check("n4_poke_count",   64'(cnt4), 64'(24));

        // Reset mid-run
        fill4(7'd7, 7'd7);
        @(posedge clk); #1;
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("abort_busy",  64'(busy[1]),  64'(0));
        check("abort_valid", 64'(valid[1]), 64'(0));
        check("abort_min",   64'(mc4),      64'(0));
        check("abort_count", 64'(cnt4),     64'(0));
        check("abort_w",     64'(w4),       64'(0));
        check("abort_j",     64'(j4),       64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        vcount = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (valid[1]) vcount++;
        end
        check("abort_no_valid", 64'(vcount),  64'(0));
        check("abort_idle",     64'(busy[1]), 64'(0));
        run(1, 400, 0, lat);
        check("restart_latency", 64'(lat),  64'(144));
        check("restart_min",     64'(mc4),  64'(28));
        check("restart_count",   64'(cnt4), 64'(24));

        // 4-bit counter saturates: 24 matches -> 15
        run(2, 400, 0, lat);
        check("sat_latency", 64'(lat),   64'(144));
        check("sat_min",     64'(mc4s),  64'(12));
        check("sat_count",   64'(cnt4s), 64'(15));
`ifdef JAM_BEST_PERM_EN
        check("sat_best",    64'(bp4s),  64'(8'hE4));
`endif

        // N=6, every cost at the CW maximum
        run(3, 7000, 0, lat);
        check("n6_latency", 64'(lat),  64'(5760));
        check("n6_min",     64'(mc6),  64'(762));
        check("n6_count",   64'(cnt6), 64'(720));
`ifdef JAM_BEST_PERM_EN
        check("n6_best",    64'(bp6),  64'(18'o543210));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
